// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data RAM between IFU and LSU, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed LSU priority.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_valid,
    output logic          ifu_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rvalid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_err,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic          lsu_we,
    input  logic [1:0]    lsu_size,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_resp,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic        OWN_IFU = 1'b0;
    localparam logic        OWN_LSU = 1'b1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  SZ_WORD = 2'd2;

    state_t      state;
    logic        owner;
    logic [15:0] wd_cnt;
    logic        pick_lsu;
    logic        accept;
    logic [1:0]  lsu_size_n;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    // On a tie the side that was not served last wins.
    always_comb begin
        pick_lsu = lsu_valid;
        if (ifu_valid && lsu_valid)
            pick_lsu = !last_lsu;
    end
`else
    assign pick_lsu = lsu_valid;
`endif

    // ready is combinational so the accept lands in the same cycle the request is seen.
    assign accept     = (state == IDLE) && !rst && (ifu_valid || lsu_valid);
    assign lsu_ready  = accept && pick_lsu;
    assign ifu_ready  = accept && !pick_lsu;
    assign lsu_size_n = (lsu_size == 2'd3) ? SZ_WORD : lsu_size;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            wd_cnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            lsu_err    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_lsu   <= OWN_IFU;
`endif
        end else begin
            // Pulses and response payload default low so they are only seen for one cycle.
            mem_req    <= 1'b0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            lsu_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= pick_lsu;
                        mem_req <= 1'b1;
                        state   <= ISSUE;
`ifdef MEM_ARB_RR_EN
                        last_lsu <= pick_lsu;
`endif
                        if (pick_lsu) begin
                            mem_we    <= lsu_we;
                            mem_size  <= lsu_size_n;
                            mem_addr  <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_size  <= SZ_WORD;
                            mem_addr  <= ifu_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // A response in the timeout cycle still counts as a good response.
                    if (mem_resp) begin
                        state <= RESP;
                        if (owner == OWN_LSU) begin
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            ifu_rvalid <= 1'b1;
                            ifu_rdata  <= mem_rdata;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        state <= RESP;
                        if (owner == OWN_LSU) begin
                            lsu_rvalid <= 1'b1;
                            lsu_err    <= 1'b1;
                        end else begin
                            ifu_rvalid <= 1'b1;
                            ifu_err    <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
